// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard, forwarding and halt/drain controller for the 5-stage CPU.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_is_halt,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemRead,
  input  logic             EX_PCSrc,
  input  logic             MEM_RegWrite,
  input  logic [4:0]       MEM_rd,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_rd,
  output logic             PCWrite,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] C_DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [DCW-1:0]   r_drain_cnt;
  logic [DCW-1:0]   w_next_cnt;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_load_use;
  logic             w_stall;
  logic             w_count_en;

  // $0 is hard-wired zero, so a load targeting it can never feed ID.
  assign w_load_use = EX_MemRead && (EX_rt != 5'd0) &&
                      ((EX_rt == ID_rs) || (EX_rt == ID_rt));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_drain_cnt;
    PCWrite      = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (EX_PCSrc) begin
          // Wrong-path instruction in ID is squashed, so its hazards don't matter.
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (w_load_use) begin
          PCWrite      = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          w_stall      = 1'b1;
        end else if (ID_is_halt) begin
          PCWrite      = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          w_next_state = S_DRAIN;
          w_next_cnt   = C_DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        PCWrite      = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
        if (r_drain_cnt == '0) begin
          w_next_state = S_HALTED;
        end else begin
          w_next_cnt = r_drain_cnt - DCW'(1);
        end
      end
      S_HALTED: begin
        PCWrite      = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end
      default: begin
        w_next_state = S_RUN;
      end
    endcase
  end

  assign w_count_en = (r_state != S_HALTED);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= S_RUN;
      r_drain_cnt   <= '0;
      r_halted      <= 1'b0;
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_cnt;
      r_halted    <= r_halted | (w_next_state == S_HALTED);
      if (w_count_en) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
  assign forwardA = (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs)) ? 2'b10 :
                    (WB_RegWrite  && (WB_rd  != 5'd0) && (WB_rd  == EX_rs)) ? 2'b01 :
                                                                              2'b00;
  assign forwardB = (MEM_RegWrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rt)) ? 2'b10 :
                    (WB_RegWrite  && (WB_rd  != 5'd0) && (WB_rd  == EX_rt)) ? 2'b01 :
                                                                              2'b00;

  assign halted      = r_halted;
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Self-checking bench: vector table with scoreboard plus halt/reset sequences.
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [4:0]       ID_rs, ID_rt, EX_rs, EX_rt, MEM_rd, WB_rd;
  logic             ID_is_halt, EX_MemRead, EX_PCSrc, MEM_RegWrite, WB_RegWrite;
  logic             PCWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, halted;
  logic [1:0]       forwardA, forwardB;
  logic [CNT_W-1:0] cycle_count, stall_count;

  pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_is_halt(ID_is_halt),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_PCSrc(EX_PCSrc),
    .MEM_RegWrite(MEM_RegWrite), .MEM_rd(MEM_rd),
    .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd),
    .PCWrite(PCWrite), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .forwardA(forwardA), .forwardB(forwardB),
    .halted(halted), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] id_rs;  logic [4:0] id_rt;  logic halt;
    logic [4:0] ex_rs;  logic [4:0] ex_rt;  logic memrd; logic pcsrc;
    logic memw; logic [4:0] mem_rd; logic wbw; logic [4:0] wb_rd;
    logic pcw; logic ifw; logic flush; logic bub; logic [1:0] fa; logic [1:0] fb;
    logic stl;
  } vec_t;

  typedef struct {
    int idx; logic pcw; logic ifw; logic flush; logic bub; logic [1:0] fa; logic [1:0] fb;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cycle;
  int   exp_stall;
  logic prev_stl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; ID_is_halt = 0; EX_rs = 0; EX_rt = 0;
    EX_MemRead = 0; EX_PCSrc = 0; MEM_RegWrite = 0; MEM_rd = 0;
    WB_RegWrite = 0; WB_rd = 0;
  endtask

  // One vector per clock: drive after the edge, compare at the falling edge.
  task automatic apply(input int i);
    exp_t e;
    @(posedge CLK);
    exp_cycle++;
    if (prev_stl) exp_stall++;
    #1;
    ID_rs = vecs[i].id_rs; ID_rt = vecs[i].id_rt; ID_is_halt = vecs[i].halt;
    EX_rs = vecs[i].ex_rs; EX_rt = vecs[i].ex_rt; EX_MemRead = vecs[i].memrd;
    EX_PCSrc = vecs[i].pcsrc; MEM_RegWrite = vecs[i].memw; MEM_rd = vecs[i].mem_rd;
    WB_RegWrite = vecs[i].wbw; WB_rd = vecs[i].wb_rd;
    prev_stl = vecs[i].stl;
    sb.push_back('{i, vecs[i].pcw, vecs[i].ifw, vecs[i].flush, vecs[i].bub,
                   vecs[i].fa, vecs[i].fb});
    @(negedge CLK);
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", i), 1, 0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_PCWrite", e.idx), PCWrite, e.pcw);
      chk($sformatf("v%0d_IF_ID_write", e.idx), IF_ID_write, e.ifw);
      chk($sformatf("v%0d_IF_ID_flush", e.idx), IF_ID_flush, e.flush);
      chk($sformatf("v%0d_ID_EX_bubble", e.idx), ID_EX_bubble, e.bub);
      chk($sformatf("v%0d_forwardA", e.idx), forwardA, e.fa);
      chk($sformatf("v%0d_forwardB", e.idx), forwardB, e.fb);
    end
    chk($sformatf("v%0d_cycle_count", i), cycle_count, exp_cycle);
    chk($sformatf("v%0d_stall_count", i), stall_count, exp_stall);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_PCWrite", PCWrite, 1);
    chk("rst_IF_ID_write", IF_ID_write, 1);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_stall_count", stall_count, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    exp_cycle = 0;
    exp_stall = 0;
    prev_stl  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    //            id_rs id_rt hlt ex_rs ex_rt mrd pcs memw mrd  wbw wrd  pcw ifw fl bub fa     fb     stl
    vecs[0]  = '{0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[1]  = '{5,  0,  0, 0, 5,  1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00, 1};
    vecs[2]  = '{0,  0,  0, 0, 0,  1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[3]  = '{1,  9,  0, 0, 9,  1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2'b00, 2'b00, 1};
    vecs[4]  = '{8,  10, 0, 0, 9,  1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[5]  = '{0,  3,  1, 0, 3,  1, 1, 0, 0, 0, 0,  1, 1, 1, 1, 2'b00, 2'b00, 0};
    vecs[6]  = '{0,  0,  0, 7, 0,  0, 0, 1, 7, 1, 7,  1, 1, 0, 0, 2'b10, 2'b00, 0};
    vecs[7]  = '{0,  0,  0, 7, 0,  0, 0, 0, 7, 1, 7,  1, 1, 0, 0, 2'b01, 2'b00, 0};
    vecs[8]  = '{0,  0,  0, 7, 0,  0, 0, 0, 7, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[9]  = '{0,  0,  0, 0, 7,  0, 0, 1, 7, 1, 7,  1, 1, 0, 0, 2'b00, 2'b10, 0};
    vecs[10] = '{0,  0,  0, 0, 7,  0, 0, 0, 7, 1, 7,  1, 1, 0, 0, 2'b00, 2'b01, 0};
    vecs[11] = '{0,  0,  0, 0, 7,  0, 0, 0, 7, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};
    vecs[12] = '{0,  0,  0, 4, 6,  0, 0, 1, 4, 1, 6,  1, 1, 0, 0, 2'b10, 2'b01, 0};
    vecs[13] = '{0,  0,  0, 0, 0,  0, 0, 1, 0, 1, 0,  1, 1, 0, 0, 2'b00, 2'b00, 0};

    clear_inputs();
    do_reset();

    repeat (10) @(posedge CLK);
    @(negedge CLK);
    exp_cycle = 10;
    chk("idle_cycle_count", cycle_count, 10);
    chk("idle_stall_count", stall_count, 0);
    chk("idle_PCWrite", PCWrite, 1);
    chk("idle_IF_ID_write", IF_ID_write, 1);
    chk("idle_flush", IF_ID_flush, 0);
    chk("idle_bubble", ID_EX_bubble, 0);
    chk("idle_fwd", {forwardA, forwardB}, 0);

    for (int i = 0; i < 14; i++) apply(i);
    apply(0);
    chk("table_stall_total", stall_count, 2);

    // Halt decoded in cycle N, drain, then HALTED from N+5.
    @(posedge CLK);
    exp_cycle++;
    #1;
    clear_inputs();
    ID_is_halt = 1'b1;
    @(negedge CLK);
    chk("halt_N_PCWrite", PCWrite, 0);
    chk("halt_N_IF_ID_write", IF_ID_write, 0);
    chk("halt_N_bubble", ID_EX_bubble, 1);
    chk("halt_N_halted", halted, 0);
    base = exp_cycle;
    for (int j = 1; j <= 4; j++) begin
      @(posedge CLK);
      #1;
      ID_is_halt = 1'b0;
      EX_PCSrc   = (j == 2);
      @(negedge CLK);
      chk($sformatf("drain_N+%0d_halted", j), halted, 0);
      chk($sformatf("drain_N+%0d_PCWrite", j), PCWrite, 0);
      chk($sformatf("drain_N+%0d_flush", j), IF_ID_flush, 0);
      chk($sformatf("drain_N+%0d_bubble", j), ID_EX_bubble, 1);
      chk($sformatf("drain_N+%0d_cycle", j), cycle_count, base + j);
    end
    EX_PCSrc = 1'b0;
    for (int j = 5; j <= 7; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("halted_N+%0d_halted", j), halted, 1);
      chk($sformatf("halted_N+%0d_PCWrite", j), PCWrite, 0);
      chk($sformatf("halted_N+%0d_cycle", j), cycle_count, base + 5);
      chk($sformatf("halted_N+%0d_stall", j), stall_count, 2);
    end

    // Reset out of HALTED, then again two cycles into a second drain.
    #2;
    do_reset();
    @(posedge CLK);
    #1;
    ID_is_halt = 1'b1;
    @(posedge CLK);
    #1;
    ID_is_halt = 1'b0;
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("middrain_rst_halted", halted, 0);
    chk("middrain_rst_PCWrite", PCWrite, 1);
    chk("middrain_rst_IF_ID_write", IF_ID_write, 1);
    chk("middrain_rst_bubble", ID_EX_bubble, 0);
    chk("middrain_rst_cycle", cycle_count, 0);
    chk("middrain_rst_stall", stall_count, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_cycle", cycle_count, 3);
    chk("post_rst_halted", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
